// File: rtl/dwt_pkg.sv
// dwt_pkg: shared types and db3 analysis coefficients for the DWT window feeder
package dwt_pkg;
   localparam int TAG_IDX_W = 16;
   localparam logic [31:0] SIGN = 32'h8000_0000;
   localparam logic [31:0] LP_COEF [6] = '{
      32'h3D10_4972, 32'hBDAE_FBD6, 32'hBE0A_4054,
      32'h3EEB_7510, 32'h3F4E_9071, 32'h3EAA_53CB
   };
   // Quadrature mirror of the low-pass: reversed taps, odd taps negated
   localparam logic [31:0] HP_COEF [6] = '{
      LP_COEF[5], LP_COEF[4] ^ SIGN, LP_COEF[3],
      LP_COEF[2] ^ SIGN, LP_COEF[1], LP_COEF[0] ^ SIGN
   };
   typedef enum logic [2:0] {PRIME, EMIT_L, EMIT_H, FILL, MIRROR} state_t;
   typedef struct packed {
      logic valid;
      logic band;
      logic [TAG_IDX_W-1:0] idx;
      logic last;
   } tag_t;
endpackage

// File: rtl/dwt_tag_delay.sv
// dwt_tag_delay: fixed-latency register line with synchronous clear
module dwt_tag_delay #(
   parameter int W = 8,
   parameter int DEPTH = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] line [DEPTH];
   always_ff @(posedge clk) begin
      if (rst) line <= '{default: '0};
      else begin
         line[0] <= d;
         for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
      end
   end
   assign q = line[DEPTH-1];
endmodule

// File: rtl/dwt_window_feeder.sv
// dwt_window_feeder: builds stride-2 6-tap windows with mirrored row edges and
// tags each issue so the PE result can be captured PE_LATENCY cycles later.
module dwt_window_feeder
   import dwt_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ROW_LEN = 64,
   parameter int PE_LATENCY = 5,
   localparam int IW = $clog2(ROW_LEN/2),
   localparam int CW = $clog2(ROW_LEN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic [DATA_WIDTH-1:0] pe_data0,
   output logic [DATA_WIDTH-1:0] pe_data1,
   output logic [DATA_WIDTH-1:0] pe_data2,
   output logic [DATA_WIDTH-1:0] pe_data3,
   output logic [DATA_WIDTH-1:0] pe_data4,
   output logic [DATA_WIDTH-1:0] pe_data5,
   output logic [DATA_WIDTH-1:0] pe_coef0,
   output logic [DATA_WIDTH-1:0] pe_coef1,
   output logic [DATA_WIDTH-1:0] pe_coef2,
   output logic [DATA_WIDTH-1:0] pe_coef3,
   output logic [DATA_WIDTH-1:0] pe_coef4,
   output logic [DATA_WIDTH-1:0] pe_coef5,
   output logic                  issue,
   output logic                  issue_band,
   output logic                  res_valid,
   output logic                  res_band,
   output logic [IW-1:0]         res_index,
   output logic                  res_last,
   output logic                  err_len
);
   state_t state, nxt;
   logic [DATA_WIDTH-1:0] win [6], win_nxt [6], pd [6], pc [6];
   logic [CW-1:0] cnt;
   logic [IW-1:0] k;
   logic ph, acc, k_last;
   tag_t tag_d, tag_q;

   assign s_ready = state == PRIME || state == FILL;
   assign acc = s_valid && s_ready;
   assign k_last = k == IW'(ROW_LEN/2-1);

   always_comb begin
      nxt = state;
      win_nxt = win;
      if (acc) win_nxt = '{win[1], win[2], win[3], win[4], win[5], s_data};
      case (state)
         PRIME: if (acc && cnt == CW'(3)) begin
            nxt = EMIT_L;
            win_nxt = '{win[5], win[4], win[3], win[4], win[5], s_data};
         end
         EMIT_L: nxt = EMIT_H;
         EMIT_H: nxt = k_last ? PRIME : (2 * int'(k) + 5 > ROW_LEN - 1) ? MIRROR : FILL;
         FILL: if (acc && cnt[0]) nxt = EMIT_L;
         MIRROR: begin
            // window holds x[N-6..N-1]: append x[N-2], then x[N-3] (shifted one slot left)
            win_nxt = '{win[1], win[2], win[3], win[4], win[5], ph ? win[2] : win[4]};
            if (ph) nxt = EMIT_L;
         end
         default: nxt = PRIME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PRIME;
         cnt <= '0;
         k <= '0;
         ph <= 1'b0;
         err_len <= 1'b0;
         issue <= 1'b0;
         issue_band <= 1'b0;
         win <= '{default: '0};
         pd <= '{default: '0};
         pc <= '{default: '0};
      end else begin
         state <= nxt;
         win <= win_nxt;
         ph <= state == MIRROR && !ph;
         if (acc) begin
            cnt <= cnt == CW'(ROW_LEN-1) ? '0 : cnt + CW'(1);
            if (s_last != (cnt == CW'(ROW_LEN-1))) err_len <= 1'b1;
         end
         if (state == EMIT_H && k_last) begin
            cnt <= '0;
            k <= '0;
         end else if (nxt == EMIT_L && state != PRIME) k <= k + IW'(1);
         issue <= nxt == EMIT_L || nxt == EMIT_H;
         issue_band <= nxt == EMIT_H;
         if (nxt == EMIT_L) pd <= win_nxt;
         if (nxt == EMIT_L || nxt == EMIT_H)
            for (int i = 0; i < 6; i++) pc[i] <= DATA_WIDTH'(nxt == EMIT_L ? LP_COEF[i] : HP_COEF[i]);
      end
   end

   assign tag_d = '{issue, issue_band, TAG_IDX_W'(k), issue_band && k_last};

   dwt_tag_delay #(.W($bits(tag_t)), .DEPTH(PE_LATENCY)) u_tag (
      .clk(clk),
      .rst(rst),
      .d(tag_d),
      .q(tag_q)
   );

   assign res_valid = tag_q.valid;
   assign res_band = tag_q.band;
   assign res_index = IW'(tag_q.idx);
   assign res_last = tag_q.last;

   assign pe_data0 = pd[0];
   assign pe_data1 = pd[1];
   assign pe_data2 = pd[2];
   assign pe_data3 = pd[3];
   assign pe_data4 = pd[4];
   assign pe_data5 = pd[5];
   assign pe_coef0 = pc[0];
   assign pe_coef1 = pc[1];
   assign pe_coef2 = pc[2];
   assign pe_coef3 = pc[3];
   assign pe_coef4 = pc[4];
   assign pe_coef5 = pc[5];
endmodule
